// File: rtl/bus_tx_queue.sv
// Transmit-side bus port: local writes queue packets, the bus arbiter pops them.
// Illegal destinations are filtered on entry; ovf/unf/err_dest are sticky.
module bus_tx_queue #(
    parameter int pckg_sz = 16,
    parameter int drvrs   = 4,
    parameter int depth   = 8,
    parameter int id      = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [pckg_sz-1:0]       wr_data,
    input  logic                     pop,
    input  logic                     clr_flags,
    output logic                     pndng,
    output logic [pckg_sz-1:0]       D_pop,
    output logic                     full,
    output logic [$clog2(depth):0]   count,
    output logic                     ovf,
    output logic                     unf,
    output logic                     err_dest
);

    localparam int aw = $clog2(depth);
    localparam logic [aw:0] depth_c = (aw+1)'(depth);

    logic [pckg_sz-1:0] mem [depth];
    logic [aw-1:0]      rd_ptr;
    logic [aw-1:0]      wr_ptr;
    logic [7:0]         dest;
    logic               dest_bad;
    logic               do_pop;
    logic               do_wr;
    logic               ovf_ev;
    logic               unf_ev;
    logic               err_ev;

    assign dest     = wr_data[pckg_sz-1 -: 8];
    assign dest_bad = (dest == 8'(id)) ||
                      ((dest >= 8'(drvrs)) && (dest != 8'hFF));

    assign full   = (count == depth_c);
    assign pndng  = (count != '0);
    assign D_pop  = pndng ? mem[rd_ptr] : '0;

    // A pop on a full queue frees the slot the write reuses on the same edge.
    assign do_pop = pop && pndng;
    assign do_wr  = wr_en && !dest_bad && (!full || do_pop);
    assign err_ev = wr_en && dest_bad;
    assign ovf_ev = wr_en && !dest_bad && full && !do_pop;
    assign unf_ev = pop && !pndng;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            unf      <= 1'b0;
            err_dest <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + aw'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + aw'(1);
            end
            if (do_wr && !do_pop) begin
                count <= count + (aw+1)'(1);
            end else if (do_pop && !do_wr) begin
                count <= count - (aw+1)'(1);
            end
            // Set wins over a same-cycle clear.
            ovf      <= (ovf && !clr_flags) || ovf_ev;
            unf      <= (unf && !clr_flags) || unf_ev;
            err_dest <= (err_dest && !clr_flags) || err_ev;
        end
    end

endmodule

// File: tb/tb_bus_tx_queue.sv
// Bench for bus_tx_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_tx_queue;

    localparam int SZ    = 16;
    localparam int DRV   = 4;
    localparam int DEPTH = 8;
    localparam int ID    = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [SZ-1:0] wr_data = '0;
    logic          pop = 1'b0;
    logic          clr_flags = 1'b0;
    logic          pndng;
    logic [SZ-1:0] D_pop;
    logic          full;
    logic [3:0]    count;
    logic          ovf;
    logic          unf;
    logic          err_dest;

    int checks = 0;
    int errors = 0;

    bus_tx_queue #(
        .pckg_sz(SZ), .drvrs(DRV), .depth(DEPTH), .id(ID)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .pop(pop), .clr_flags(clr_flags), .pndng(pndng), .D_pop(D_pop),
        .full(full), .count(count), .ovf(ovf), .unf(unf),
        .err_dest(err_dest)
    );

    always #5 clk = ~clk;

    // Reference model: an ordinary queue plus three flag bits.
    logic [SZ-1:0] q[$];
    bit m_ovf, m_unf, m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
            m_err = 0;
        end else begin
            int  n;
            bit  bad, pok, wok;
            int  d;
            d   = int'(wr_data[SZ-1:SZ-8]);
            bad = (d == ID) || (d >= DRV && d != 255);
            n   = q.size();
            pok = pop && n > 0;
            wok = wr_en && !bad && (n < DEPTH || pok);
            if (clr_flags) begin
                m_ovf = 0;
                m_unf = 0;
                m_err = 0;
            end
            if (wr_en && bad) m_err = 1;
            if (wr_en && !bad && !wok) m_ovf = 1;
            if (pop && n == 0) m_unf = 1;
            if (pok) void'(q.pop_front());
            if (wok) q.push_back(wr_data);
        end
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_pndng", 32'(pndng), 32'(q.size() > 0));
            chk("m_full", 32'(full), 32'(q.size() == DEPTH));
            chk("m_dpop", 32'(D_pop), (q.size() > 0) ? 32'(q[0]) : 32'h0);
            chk("m_flags", {29'b0, ovf, unf, err_dest},
                {29'b0, m_ovf, m_unf, m_err});
        end
    end

    task automatic step(bit w, logic [SZ-1:0] d, bit p, bit c);
        wr_en     = w;
        wr_data   = d;
        pop       = p;
        clr_flags = c;
        @(negedge clk);
        wr_en     = 1'b0;
        pop       = 1'b0;
        clr_flags = 1'b0;
    endtask

    function automatic logic [SZ-1:0] legal_pkt();
        logic [7:0] dsel [4];
        dsel[0] = 8'h01;
        dsel[1] = 8'h02;
        dsel[2] = 8'h03;
        dsel[3] = 8'hFF;
        return {dsel[$urandom_range(0, 3)], 8'($urandom)};
    endfunction

    task automatic chk_reset_vals(string nm);
        chk({nm, "_count"}, 32'(count), 32'h0);
        chk({nm, "_pndng"}, 32'(pndng), 32'h0);
        chk({nm, "_full"}, 32'(full), 32'h0);
        chk({nm, "_dpop"}, 32'(D_pop), 32'h0);
        chk({nm, "_flags"}, {29'b0, ovf, unf, err_dest}, 32'h0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // 1: basic FIFO with 1-cycle latency
        step(1, 16'h01AB, 0, 0);
        chk("t1_pndng", 32'(pndng), 32'h1);
        chk("t1_dpop0", 32'(D_pop), 32'h01AB);
        step(1, 16'h02CC, 0, 0);
        step(0, '0, 1, 0);
        chk("t1_dpop1", 32'(D_pop), 32'h02CC);
        step(0, '0, 1, 0);
        chk("t1_empty", 32'(pndng), 32'h0);
        chk("t1_count", 32'(count), 32'h0);

        // 2: overflow
        for (int i = 0; i < 8; i++) step(1, {8'h01, 8'(i)}, 0, 0);
        step(1, 16'h0311, 0, 0);
        chk("t2_full", 32'(full), 32'h1);
        chk("t2_count", 32'(count), 32'h8);
        chk("t2_ovf", 32'(ovf), 32'h1);
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
        chk("t2_last", 32'(D_pop), 32'h0107);
        step(0, '0, 1, 1);
        chk("t2_drained", 32'(count), 32'h0);

        // 3: write+pop on full queue
        for (int i = 0; i < 8; i++) step(1, {8'h02, 8'(i)}, 0, 0);
        step(1, 16'h0177, 1, 0);
        chk("t3_count", 32'(count), 32'h8);
        chk("t3_full", 32'(full), 32'h1);
        chk("t3_ovf", 32'(ovf), 32'h0);
        for (int i = 0; i < 7; i++) step(0, '0, 1, 0);
        chk("t3_last", 32'(D_pop), 32'h0177);
        step(0, '0, 1, 0);

        // 4: destination filter
        step(1, 16'h00FF, 0, 0);
        chk("t4_err_self", 32'(err_dest), 32'h1);
        chk("t4_cnt0", 32'(count), 32'h0);
        step(0, '0, 0, 1);
        step(1, 16'h0510, 0, 0);
        chk("t4_err_range", 32'(err_dest), 32'h1);
        step(1, 16'hFF10, 0, 1);
        chk("t4_bcast", 32'(count), 32'h1);
        chk("t4_bcast_dpop", 32'(D_pop), 32'hFF10);
        chk("t4_err_clr", 32'(err_dest), 32'h0);
        step(0, '0, 1, 0);

        // 5: underflow and clear
        step(0, '0, 1, 0);
        chk("t5_unf", 32'(unf), 32'h1);
        chk("t5_cnt", 32'(count), 32'h0);
        step(1, 16'h0342, 1, 0);
        chk("t5_wr_empty_pop", 32'(count), 32'h1);
        step(0, '0, 1, 1);
        chk("t5_clr", {29'b0, ovf, unf, err_dest}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [SZ-1:0] d;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) d = legal_pkt();
            else if (r == 7) d = {8'h00, 8'($urandom)};
            else d = {8'($urandom_range(4, 254)), 8'($urandom)};
            step($urandom_range(0, 2) != 0, d, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 1) == 1, legal_pkt(),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
        end

        // 6: pointer wrap then reset mid-burst
        step(1, 16'h0101, 0, 0);
        for (int i = 0; i < 12; i++) step(1, {8'h02, 8'(i)}, 1, 0);
        chk("t6_cnt", 32'(count), 32'(q.size()));
        wr_en   = 1'b1;
        wr_data = 16'h0399;
        pop     = 1'b1;
        #2 reset = 1'b1;
        #1 chk_reset_vals("t6_rst");
        @(negedge clk);
        wr_en = 1'b0;
        pop   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1, 16'h0155, 0, 0);
        chk("t6_after", 32'(D_pop), 32'h0155);
        step(0, '0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
